// File: rtl/prm_pkg.sv
// Shared types for the programmable PRM edge-mask engine: FSM states, cube
// table entry layout and the index-width helper.
package prm_pkg;

  localparam int PRM_IN_W = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_e;

  // One product term: care selects the literals, val gives their polarity.
  typedef struct packed {
    logic [PRM_IN_W-1:0] care;
    logic [PRM_IN_W-1:0] val;
  } cube_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prm_edge_mask_engine_if.sv
// Query/result stream between the edge sequencer (master) and the mask
// engine (slave).
interface prm_edge_mask_engine_if #(
  parameter int IN_W  = 15,
  parameter int ID_W  = 16,
  parameter int DEPTH = 256
);
  localparam int AW = prm_pkg::idx_w(DEPTH);

  logic            q_valid;
  logic            q_ready;
  logic [IN_W-1:0] q_bits;
  logic [ID_W-1:0] q_id;

  logic            r_valid;
  logic            r_ready;
  logic [ID_W-1:0] r_id;
  logic            r_mask;
  logic [AW-1:0]   r_hit_idx;

  modport master (
    output q_valid, q_bits, q_id, r_ready,
    input  q_ready, r_valid, r_id, r_mask, r_hit_idx
  );

  modport slave (
    input  q_valid, q_bits, q_id, r_ready,
    output q_ready, r_valid, r_id, r_mask, r_hit_idx
  );
endinterface

// File: rtl/prm_cube_match.sv
// Single lane comparator: cube matches when every cared literal agrees with
// the query, and only if its table index is below the active count.
module prm_cube_match
  import prm_pkg::*;
#(
  parameter int IN_W = PRM_IN_W,
  parameter int CW   = 9
) (
  input  logic [IN_W-1:0] bits,
  input  cube_t           cube,
  input  logic [CW-1:0]   idx,
  input  logic [CW-1:0]   count,
  output logic            hit
);
  assign hit = (((bits ^ cube.val) & cube.care) == '0) && (idx < count);
endmodule

// File: rtl/prm_edge_mask_engine.sv
// Run-time loadable sum-of-products edge checker: scans LANES cubes per cycle
// and reports the first matching cube index for each queried configuration.
module prm_edge_mask_engine
  import prm_pkg::*;
#(
  parameter int IN_W  = PRM_IN_W,
  parameter int DEPTH = 256,
  parameter int LANES = 4,
  parameter int ID_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [idx_w(DEPTH)-1:0] cfg_addr,
  input  logic [IN_W-1:0]         cfg_care,
  input  logic [IN_W-1:0]         cfg_val,
  input  logic                    cfg_count_we,
  input  logic [idx_w(DEPTH):0]   cfg_count,
  output logic                    cfg_drop,
  output logic                    busy,
  prm_edge_mask_engine_if.slave   bus
);
  localparam int AW = idx_w(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = idx_w(LANES);
  localparam logic [CW-1:0] LANES_C = CW'(LANES);

  cube_t     table_q [DEPTH];
  state_e    state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [IN_W-1:0] bits_q;
  logic [ID_W-1:0] id_q;
  logic            mask_q;
  logic [AW-1:0]   hit_q;
  logic [CW-1:0]   count_q;
  logic            rdy_en_q;
  logic            cfg_drop_q;

  // Old contents of a cube overwritten in the same cycle a query is accepted.
  logic            shd_vld_q;
  logic [AW-1:0]   shd_addr_q;
  cube_t           shd_cube_q;

  logic accept, busy_w, scan_done, scan_last, any_hit;
  logic [LW-1:0]   first_lane;
  logic [LANES-1:0]         lane_hit;
  cube_t [LANES-1:0]        lane_cube;
  logic [LANES-1:0][AW-1:0] lane_idx;
  logic [LANES-1:0][CW-1:0] lane_idx_c;

  assign busy_w  = (state_q != IDLE);
  assign accept  = bus.q_valid && bus.q_ready;

  assign bus.q_ready   = (state_q == IDLE) && rdy_en_q;
  assign bus.r_valid   = (state_q == RESP);
  assign bus.r_id      = id_q;
  assign bus.r_mask    = mask_q;
  assign bus.r_hit_idx = hit_q;
  assign busy          = busy_w;
  assign cfg_drop      = cfg_drop_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l]   = ptr_q + AW'(l);
    assign lane_idx_c[l] = {1'b0, lane_idx[l]};
    assign lane_cube[l]  = (shd_vld_q && (shd_addr_q == lane_idx[l])) ? shd_cube_q
                                                                       : table_q[lane_idx[l]];
  end

  prm_cube_match #(.IN_W(IN_W), .CW(CW)) u_lane [LANES-1:0] (
    .bits  (bits_q),
    .cube  (lane_cube),
    .idx   (lane_idx_c),
    .count (count_q),
    .hit   (lane_hit)
  );

  // Lowest lane wins: scan from the top so the last assignment is the lowest.
  always_comb begin
    any_hit    = 1'b0;
    first_lane = '0;
    for (int l = LANES-1; l >= 0; l--) begin
      if (lane_hit[l]) begin
        any_hit    = 1'b1;
        first_lane = LW'(l);
      end
    end
  end

  assign scan_last = (({1'b0, ptr_q} + LANES_C) >= count_q);
  assign scan_done = (state_q == SCAN) && (any_hit || scan_last);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = SCAN;
        ptr_d   = '0;
      end
      SCAN: begin
        if (any_hit || scan_last) state_d = RESP;
        else                      ptr_d   = ptr_q + AW'(LANES);
      end
      RESP: if (bus.r_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      bits_q     <= '0;
      id_q       <= '0;
      mask_q     <= 1'b0;
      hit_q      <= '0;
      count_q    <= '0;
      rdy_en_q   <= 1'b0;
      cfg_drop_q <= 1'b0;
      shd_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rdy_en_q   <= 1'b1;
      cfg_drop_q <= busy_w && (cfg_we || cfg_count_we);
      if (accept) begin
        bits_q    <= bus.q_bits;
        id_q      <= bus.q_id;
        shd_vld_q <= cfg_we;
      end else if ((state_q == RESP) && bus.r_ready) begin
        shd_vld_q <= 1'b0;
      end
      if (scan_done) begin
        mask_q <= any_hit;
        hit_q  <= any_hit ? (ptr_q + AW'(first_lane)) : '0;
      end
      if (!busy_w && cfg_count_we) count_q <= cfg_count;
    end
  end

  // Table and shadow carry no reset; count=0 keeps stale contents invisible.
  always_ff @(posedge clk) begin
    if (!busy_w && cfg_we) table_q[cfg_addr] <= '{care: cfg_care, val: cfg_val};
    if (accept) begin
      shd_addr_q <= cfg_addr;
      shd_cube_q <= table_q[cfg_addr];
    end
  end

endmodule
